// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory signals of the line arbiter.
// The arbiter uses the master modport; the caches and memory use the slave modport.
interface cache_mem_arbiter_if #(
    parameter int LINE_WORDS = 4
);
    localparam int BW = $clog2(LINE_WORDS);

    logic          ic_req;
    logic [31:0]   ic_addr;
    logic          ic_rvalid;
    logic [31:0]   ic_rdata;
    logic [BW-1:0] ic_rbeat;
    logic          ic_done;

    logic          dc_req;
    logic          dc_we;
    logic [31:0]   dc_addr;
    logic [31:0]   dc_wdata;
    logic          dc_wnext;
    logic          dc_rvalid;
    logic [31:0]   dc_rdata;
    logic [BW-1:0] dc_rbeat;
    logic          dc_done;

    logic          mem_en;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          busy;
    logic          owner;

    modport master (
        input  ic_req, ic_addr,
        output ic_rvalid, ic_rdata, ic_rbeat, ic_done,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        output dc_wnext, dc_rvalid, dc_rdata, dc_rbeat, dc_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport slave (
        output ic_req, ic_addr,
        input  ic_rvalid, ic_rdata, ic_rbeat, ic_done,
        output dc_req, dc_we, dc_addr, dc_wdata,
        input  dc_wnext, dc_rvalid, dc_rdata, dc_rbeat, dc_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the I-cache
// refill path and the D-cache refill/write-back path, one cache line per grant.
module cache_mem_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int MEM_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    cache_mem_arbiter_if.master  bus
);
    localparam int              BW        = $clog2(LINE_WORDS);
    localparam int              WW        = $clog2(MEM_LAT + 1);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [WW-1:0]   LAT       = WW'(MEM_LAT);
    localparam logic [31:0]     LINE_MASK = ~32'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t        state;
    logic          owner_r;
    logic          last_owner;
    logic          we_r;
    logic [31:0]   base_addr;
    logic [BW-1:0] beat;
    logic [WW-1:0] wait_cnt;

    logic          mem_en_r;
    logic          mem_we_r;
    logic [31:0]   mem_addr_r;
    logic          wnext_r;
    logic          ic_rvalid_r;
    logic          dc_rvalid_r;
    logic [BW-1:0] rbeat_r;
    logic          ic_done_r;
    logic          dc_done_r;
    logic          busy_r;

    logic          grant_d;
    logic          grant_we;
    logic [31:0]   grant_base;

    // On a conflict the side that did not own the previous transfer wins.
    assign grant_d    = bus.dc_req && (!bus.ic_req || !last_owner);
    assign grant_we   = grant_d && bus.dc_we;
    assign grant_base = (grant_d ? bus.dc_addr : bus.ic_addr) & LINE_MASK;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            owner_r     <= 1'b0;
            last_owner  <= 1'b1;
            we_r        <= 1'b0;
            base_addr   <= '0;
            beat        <= '0;
            wait_cnt    <= '0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            wnext_r     <= 1'b0;
            ic_rvalid_r <= 1'b0;
            dc_rvalid_r <= 1'b0;
            rbeat_r     <= '0;
            ic_done_r   <= 1'b0;
            dc_done_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            wnext_r     <= 1'b0;
            ic_rvalid_r <= 1'b0;
            dc_rvalid_r <= 1'b0;
            ic_done_r   <= 1'b0;
            dc_done_r   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.ic_req || bus.dc_req) begin
                        state      <= XFER;
                        busy_r     <= 1'b1;
                        owner_r    <= grant_d;
                        we_r       <= grant_we;
                        base_addr  <= grant_base;
                        beat       <= '0;
                        wait_cnt   <= '0;
                        mem_en_r   <= 1'b1;
                        mem_we_r   <= grant_we;
                        mem_addr_r <= grant_base;
                        wnext_r    <= grant_we;
                    end
                end

                XFER: begin
                    // Strobes are registered, so each one is set on the edge before its cycle.
                    if (wait_cnt != LAT) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == LAT - 1'b1 && !we_r) begin
                            ic_rvalid_r <= !owner_r;
                            dc_rvalid_r <= owner_r;
                            rbeat_r     <= beat;
                        end
                    end else if (beat == LAST_BEAT) begin
                        state     <= DONE;
                        ic_done_r <= !owner_r;
                        dc_done_r <= owner_r;
                        beat      <= '0;
                        wait_cnt  <= '0;
                    end else begin
                        beat       <= beat + 1'b1;
                        wait_cnt   <= '0;
                        mem_en_r   <= 1'b1;
                        mem_we_r   <= we_r;
                        mem_addr_r <= base_addr + ((32'(beat) + 32'd1) << 2);
                        wnext_r    <= we_r;
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    busy_r     <= 1'b0;
                    last_owner <= owner_r;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data paths are pass-through; only their qualifiers are registered.
    assign bus.mem_wdata = (mem_en_r && mem_we_r) ? bus.dc_wdata : 32'd0;
    assign bus.ic_rdata  = ic_rvalid_r ? bus.mem_rdata : 32'd0;
    assign bus.dc_rdata  = dc_rvalid_r ? bus.mem_rdata : 32'd0;

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.dc_wnext  = wnext_r;
    assign bus.ic_rvalid = ic_rvalid_r;
    assign bus.dc_rvalid = dc_rvalid_r;
    assign bus.ic_rbeat  = rbeat_r;
    assign bus.dc_rbeat  = rbeat_r;
    assign bus.ic_done   = ic_done_r;
    assign bus.dc_done   = dc_done_r;
    assign bus.busy      = busy_r;
    assign bus.owner     = owner_r;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a fixed-latency memory model.
// Cycle 0 is the cycle a request is first driven; outputs are sampled 1 time unit after each edge.
module tb_cache_mem_arbiter;
    localparam int LINE_WORDS = 4;
    localparam int MEM_LAT    = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] wr_words [4];

    cache_mem_arbiter_if #(.LINE_WORDS(LINE_WORDS)) bus ();

    cache_mem_arbiter #(
        .LINE_WORDS (LINE_WORDS),
        .MEM_LAT    (MEM_LAT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3C3_5A5A;
    endfunction

    // Memory returns the word two cycles after a read strobe.
    logic        p1_v = 1'b0;
    logic        p2_v = 1'b0;
    logic [31:0] p1_a = 32'd0;
    logic [31:0] p2_a = 32'd0;
    always @(posedge clk) begin
        p1_v <= bus.mem_en && !bus.mem_we;
        p1_a <= bus.mem_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign bus.mem_rdata = p2_v ? mem_word(p2_a) : 32'h0BAD_0BAD;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_strobes(input string tag);
        check_output({tag, " busy"},      bus.busy,      1'b0);
        check_output({tag, " mem_en"},    bus.mem_en,    1'b0);
        check_output({tag, " mem_we"},    bus.mem_we,    1'b0);
        check_output({tag, " dc_wnext"},  bus.dc_wnext,  1'b0);
        check_output({tag, " ic_rvalid"}, bus.ic_rvalid, 1'b0);
        check_output({tag, " dc_rvalid"}, bus.dc_rvalid, 1'b0);
        check_output({tag, " ic_done"},   bus.ic_done,   1'b0);
        check_output({tag, " dc_done"},   bus.dc_done,   1'b0);
    endtask

    // Checks cycles 1..14 of one line transfer owned by 'side' (0 = I, 1 = D).
    task automatic run_xfer(input logic side, input logic we, input logic [31:0] addr,
                            input int drop_at, input logic raise_dc);
        logic [31:0] base;
        logic        exp_en;
        logic        exp_rv;
        int          k;
        int          b;
        int          wpend;
        base  = addr & 32'hFFFF_FFF0;
        wpend = -1;
        for (int c = 1; c <= 14; c++) begin
            next_cycle();
            if (wpend >= 0) begin
                bus.dc_wdata = wr_words[wpend];
                wpend = -1;
            end
            k      = c - 1;
            b      = k / 3;
            exp_en = (c <= 12) && (k % 3 == 0);
            exp_rv = (c <= 12) && (k % 3 == 2) && !we;
            check_output("mem_en",   bus.mem_en,   exp_en);
            check_output("mem_we",   bus.mem_we,   exp_en && we);
            check_output("dc_wnext", bus.dc_wnext, exp_en && we);
            if (exp_en) begin
                check_output("mem_addr", bus.mem_addr, base + 32'(4 * b));
                if (we) begin
                    check_output("mem_wdata", bus.mem_wdata, wr_words[b]);
                    if (b < 3) wpend = b + 1;
                end
            end
            check_output("ic_rvalid", bus.ic_rvalid, exp_rv && !side);
            check_output("dc_rvalid", bus.dc_rvalid, exp_rv && side);
            if (exp_rv) begin
                if (side) begin
                    check_output("dc_rdata", bus.dc_rdata, mem_word(base + 32'(4 * b)));
                    check_output("dc_rbeat", 32'(bus.dc_rbeat), 32'(b));
                end else begin
                    check_output("ic_rdata", bus.ic_rdata, mem_word(base + 32'(4 * b)));
                    check_output("ic_rbeat", 32'(bus.ic_rbeat), 32'(b));
                end
            end
            check_output("ic_done", bus.ic_done, (c == 13) && !side);
            check_output("dc_done", bus.dc_done, (c == 13) && side);
            check_output("busy",    bus.busy,    c <= 13);
            if (c <= 13) check_output("owner", bus.owner, side);
            if (c == drop_at || c == 13) begin
                if (side) bus.dc_req = 1'b0;
                else      bus.ic_req = 1'b0;
            end
            if (raise_dc && c == 1) bus.dc_req = 1'b1;
        end
    endtask

    initial begin
        bus.ic_req   = 1'b0;
        bus.ic_addr  = 32'd0;
        bus.dc_req   = 1'b0;
        bus.dc_we    = 1'b0;
        bus.dc_addr  = 32'd0;
        bus.dc_wdata = 32'd0;
        wr_words[0]  = 32'hA0A0_0000;
        wr_words[1]  = 32'hA1A1_1111;
        wr_words[2]  = 32'hA2A2_2222;
        wr_words[3]  = 32'hA3A3_3333;

        $display("[TB] reset and I-cache refill at 0x128");
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();
        check_idle_strobes("reset");
        check_output("reset owner", bus.owner, 1'b0);
        resetn      = 1'b1;
        bus.ic_addr = 32'h0000_0128;
        bus.ic_req  = 1'b1;
        run_xfer(1'b0, 1'b0, 32'h0000_0128, 0, 1'b0);

        $display("[TB] D-cache write-back at 0x2004");
        bus.dc_we    = 1'b1;
        bus.dc_addr  = 32'h0000_2004;
        bus.dc_wdata = wr_words[0];
        bus.dc_req   = 1'b1;
        run_xfer(1'b1, 1'b1, 32'h0000_2004, 0, 1'b0);
        bus.dc_we = 1'b0;

        $display("[TB] simultaneous requests after reset");
        resetn = 1'b0;
        next_cycle();
        next_cycle();
        resetn      = 1'b1;
        bus.ic_addr = 32'h0000_1000;
        bus.dc_addr = 32'h0000_7010;
        bus.ic_req  = 1'b1;
        bus.dc_req  = 1'b1;
        run_xfer(1'b0, 1'b0, 32'h0000_1000, 0, 1'b0);
        run_xfer(1'b1, 1'b0, 32'h0000_7010, 0, 1'b0);
        bus.ic_addr = 32'h0000_1020;
        bus.dc_addr = 32'h0000_7020;
        bus.ic_req  = 1'b1;
        bus.dc_req  = 1'b1;
        run_xfer(1'b0, 1'b0, 32'h0000_1020, 0, 1'b0);
        run_xfer(1'b1, 1'b0, 32'h0000_7020, 0, 1'b0);

        $display("[TB] reset during beat 2 of a D refill");
        bus.dc_addr = 32'h0000_3008;
        bus.dc_req  = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            check_output("abort mem_en", bus.mem_en, (c == 1) || (c == 4) || (c == 7));
        end
        check_output("abort beat2 addr", bus.mem_addr, 32'h0000_3008);
        resetn     = 1'b0;
        bus.dc_req = 1'b0;
        next_cycle();
        check_idle_strobes("abort");
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            check_idle_strobes("after abort");
        end
        bus.ic_addr = 32'h0000_4444;
        bus.ic_req  = 1'b1;
        run_xfer(1'b0, 1'b0, 32'h0000_4444, 0, 1'b0);

        $display("[TB] I request dropped mid-transfer with D pending");
        bus.ic_addr = 32'h0000_5004;
        bus.dc_addr = 32'h0000_6010;
        bus.ic_req  = 1'b1;
        run_xfer(1'b0, 1'b0, 32'h0000_5004, 5, 1'b1);
        run_xfer(1'b1, 1'b0, 32'h0000_6010, 0, 1'b0);

        $display("[TB] D refill at top of address space");
        bus.dc_addr = 32'hFFFF_FFF4;
        bus.dc_req  = 1'b1;
        run_xfer(1'b1, 1'b0, 32'hFFFF_FFF4, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
